asg_seq_ctrl: RTL and testbench
===============================

ASG_SEQ_CTRL -- requirements
Module: asg_seq_ctrl

Interface
REQ-001 SHALL have parameter RSZ, default 14, meaning buffer address width of the sequenced ASG channel.
REQ-002 SHALL have parameter SAW, default 3, meaning segment-table index width (2^SAW entries).
REQ-003 SHALL have port dac_clk_i  in  1  the single clock; all logic rises on it.
REQ-004 SHALL have port dac_rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port cfg_we_i  in  1  table write strobe.
REQ-006 SHALL have port cfg_idx_i  in  SAW  table entry written.
REQ-007 SHALL have port cfg_ofs_i  in  RSZ+16  segment start pointer, 16 fractional bits.
REQ-008 SHALL have port cfg_size_i  in  RSZ+16  segment size, same format.
REQ-009 SHALL have port cfg_nrep_i  in  16  wraps per segment; 0 means 1.
REQ-010 SHALL have port cfg_last_i  in  SAW  index of the last segment in the sequence.
REQ-011 SHALL have port cfg_loop_i  in  1  1 = restart at segment 0 after the last segment.
REQ-012 SHALL have port start_i  in  1  start pulse.
REQ-013 SHALL have port stop_i  in  1  abort pulse.
REQ-014 SHALL have port wrap_evt_i  in  1  channel trigger-done pulse, channel configured for start/wrap events.
REQ-015 SHALL have port set_ofs_o  out  RSZ+16  channel start pointer.
REQ-016 SHALL have port set_size_o  out  RSZ+16  channel table size.
REQ-017 SHALL have port set_rst_o  out  1  channel FSM reset pulse.
REQ-018 SHALL have port trig_sw_o  out  1  channel software trigger pulse.
REQ-019 SHALL have port trig_src_o  out  3  channel trigger source; 3'd1 while busy, 3'd0 otherwise.
REQ-020 SHALL have port seg_o  out  SAW  current segment index.
REQ-021 SHALL have port busy_o  out  1  high in every state except IDLE.
REQ-022 SHALL have port done_o  out  1  one-cycle pulse when the sequence completes normally.
REQ-023 SHALL have port cfg_err_o  out  1  sticky flag: table write attempted while busy.

Function
REQ-024 SHALL hold a 2^SAW-entry table {ofs, size, nrep}; cfg_we_i in IDLE writes entry cfg_idx_i on the next edge.
REQ-025 SHALL ignore cfg_we_i while busy_o=1, leave the table unchanged, and set cfg_err_o; start_i accepted from IDLE clears cfg_err_o.
REQ-026 SHALL implement FSM states IDLE, LOAD, ARM, RUN, NEXT.
REQ-027 IDLE: start_i=1 and stop_i=0 -> LOAD with seg=0; start_i in any other state SHALL be ignored.
REQ-028 LOAD (1 cycle): set_ofs_o/set_size_o registered from table[seg], wrap counter <= max(nrep,1), started flag cleared, set_rst_o=1 during this state -> ARM.
REQ-029 ARM (1 cycle): trig_sw_o=1, set_rst_o=0 -> RUN.
REQ-030 RUN: the first wrap_evt_i sets started (start event, not counted); each later wrap_evt_i decrements the counter; a decrement from 1 -> NEXT.
REQ-031 SHALL ignore wrap_evt_i in IDLE, LOAD, ARM and NEXT.
REQ-032 NEXT (1 cycle): if seg<cfg_last_i, seg+1 -> LOAD; else if cfg_loop_i, seg=0 -> LOAD; else -> IDLE with done_o=1 in this cycle.
REQ-033 cfg_last_i and cfg_loop_i SHALL be sampled live in NEXT; table entries SHALL be sampled in LOAD.
REQ-034 stop_i in any non-IDLE state SHALL force IDLE on the next edge, pulse set_rst_o for that cycle, and suppress done_o; stop_i SHALL override start_i and wrap_evt_i in the same cycle.
REQ-035 set_ofs_o and set_size_o SHALL hold their last value in IDLE.
REQ-036 seg_o SHALL equal the segment counter; segment counter arithmetic SHALL wrap modulo 2^SAW.

Reset
REQ-037 dac_rst_i=1 SHALL, on the next edge, force IDLE, zero all outputs, zero seg, the counters and started, and zero all table entries; this SHALL take priority over every other input, including mid-sequence.

Verification
REQ-038 Load seg0 {ofs=0, size=0x3FFF_FFFF, nrep=2}, last=0, loop=0; start -> set_rst_o in cycle 1, trig_sw_o in cycle 2; three wrap_evt_i pulses -> done_o one cycle after the third; busy_o then 0.
REQ-039 Three segments with nrep=1, last=2, loop=1 -> seg_o sequence 0,1,2,0 with set_ofs_o matching each entry; stop_i while seg=1 -> IDLE next cycle, set_rst_o=1 once, no done_o.
REQ-040 nrep=0 -> segment ends after start event plus one wrap, identical to nrep=1.
REQ-041 cfg_we_i during RUN -> table unchanged (read back via a later LOAD), cfg_err_o=1; the next start clears it.
REQ-042 start_i and stop_i together in IDLE -> stays IDLE; wrap_evt_i pulses during ARM -> not counted.
REQ-043 dac_rst_i asserted during RUN with counter=5 -> all outputs 0 next cycle; a subsequent start loads ofs=0, size=0.

Source files
------------

// File: rtl/asg_seq_ctrl.sv
// Segment sequencer for one ASG channel. Holds a small table of
// {start pointer, size, repeat count} segments and walks through them,
// reprogramming and retriggering the channel at each segment boundary.
//
//  state | meaning
//  IDLE  | waiting for start; the segment table may be written
//  LOAD  | present table[seg] to the channel, hold the channel FSM in reset
//  ARM   | fire the software trigger for the freshly loaded segment
//  RUN   | count channel wrap events until the segment's repeats are used up
//  NEXT  | choose the next segment, restart from 0, or finish
module asg_seq_ctrl #(
   parameter int RSZ = 14,
   parameter int SAW = 3
) (
   input  logic              dac_clk_i,
   input  logic              dac_rst_i,
   input  logic              cfg_we_i,
   input  logic [SAW-1:0]    cfg_idx_i,
   input  logic [RSZ+15:0]   cfg_ofs_i,
   input  logic [RSZ+15:0]   cfg_size_i,
   input  logic [15:0]       cfg_nrep_i,
   input  logic [SAW-1:0]    cfg_last_i,
   input  logic              cfg_loop_i,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic              wrap_evt_i,
   output logic [RSZ+15:0]   set_ofs_o,
   output logic [RSZ+15:0]   set_size_o,
   output logic              set_rst_o,
   output logic              trig_sw_o,
   output logic [2:0]        trig_src_o,
   output logic [SAW-1:0]    seg_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              cfg_err_o
);

   localparam int NSEG = 1 << SAW;
   localparam int PW   = RSZ + 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ARM,
      ST_RUN,
      ST_NEXT
   } state_t;

   state_t          r_state;
   logic [PW-1:0]   r_tbl_ofs  [NSEG];
   logic [PW-1:0]   r_tbl_size [NSEG];
   logic [15:0]     r_tbl_nrep [NSEG];
   logic [PW-1:0]   r_set_ofs;
   logic [PW-1:0]   r_set_size;
   logic            r_set_rst;
   logic            r_trig_sw;
   logic [SAW-1:0]  r_seg;
   logic [15:0]     r_cnt;
   logic            r_started;
   logic            r_cfg_err;
   logic            w_busy;
   logic            w_last_seg;
   logic            w_done;

   assign w_busy     = (r_state != ST_IDLE);
   // A live stop in NEXT aborts the sequence, so it must also mask done.
   assign w_last_seg = !(r_seg < cfg_last_i) && !cfg_loop_i;
   assign w_done     = (r_state == ST_NEXT) && w_last_seg && !stop_i;

   // Segment table: writable only while idle, cleared by reset.
   always_ff @(posedge dac_clk_i) begin
      if (dac_rst_i) begin
         for (int i = 0; i < NSEG; i++) begin
            r_tbl_ofs[i]  <= '0;
            r_tbl_size[i] <= '0;
            r_tbl_nrep[i] <= '0;
         end
      end else if (cfg_we_i && !w_busy) begin
         r_tbl_ofs[cfg_idx_i]  <= cfg_ofs_i;
         r_tbl_size[cfg_idx_i] <= cfg_size_i;
         r_tbl_nrep[cfg_idx_i] <= cfg_nrep_i;
      end
   end

   // Sequencer FSM with registered channel-control outputs.
   always_ff @(posedge dac_clk_i) begin
      if (dac_rst_i) begin
         r_state    <= ST_IDLE;
         r_set_ofs  <= '0;
         r_set_size <= '0;
         r_set_rst  <= 1'b0;
         r_trig_sw  <= 1'b0;
         r_seg      <= '0;
         r_cnt      <= '0;
         r_started  <= 1'b0;
         r_cfg_err  <= 1'b0;
      end else begin
         r_set_rst <= 1'b0;
         r_trig_sw <= 1'b0;
         if (cfg_we_i && w_busy)
            r_cfg_err <= 1'b1;
         if (stop_i && w_busy) begin
            r_state   <= ST_IDLE;
            r_set_rst <= 1'b1;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (start_i && !stop_i) begin
                     r_state   <= ST_LOAD;
                     r_seg     <= '0;
                     r_set_rst <= 1'b1;
                     r_cfg_err <= 1'b0;
                  end
               end
               ST_LOAD: begin
                  r_set_ofs  <= r_tbl_ofs[r_seg];
                  r_set_size <= r_tbl_size[r_seg];
                  // A repeat count of 0 behaves exactly like 1.
                  r_cnt      <= (r_tbl_nrep[r_seg] == 16'd0) ? 16'd1 : r_tbl_nrep[r_seg];
                  r_started  <= 1'b0;
                  r_trig_sw  <= 1'b1;
                  r_state    <= ST_ARM;
               end
               ST_ARM: begin
                  r_state <= ST_RUN;
               end
               ST_RUN: begin
                  // The first event after the trigger is the channel's start
                  // event, not a completed wrap.
                  if (wrap_evt_i) begin
                     if (!r_started) begin
                        r_started <= 1'b1;
                     end else begin
                        r_cnt <= r_cnt - 16'd1;
                        if (r_cnt == 16'd1)
                           r_state <= ST_NEXT;
                     end
                  end
               end
               ST_NEXT: begin
                  if (r_seg < cfg_last_i) begin
                     r_seg     <= r_seg + 1'b1;
                     r_state   <= ST_LOAD;
                     r_set_rst <= 1'b1;
                  end else if (cfg_loop_i) begin
                     r_seg     <= '0;
                     r_state   <= ST_LOAD;
                     r_set_rst <= 1'b1;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign set_ofs_o  = r_set_ofs;
   assign set_size_o = r_set_size;
   assign set_rst_o  = r_set_rst;
   assign trig_sw_o  = r_trig_sw;
   assign trig_src_o = w_busy ? 3'd1 : 3'd0;
   assign seg_o      = r_seg;
   assign busy_o     = w_busy;
   assign done_o     = w_done;
   assign cfg_err_o  = r_cfg_err;

endmodule

// File: tb/tb_asg_seq_ctrl.sv
// Directed bench for the ASG segment sequencer.
module tb_asg_seq_ctrl;

   localparam int RSZ = 14;
   localparam int SAW = 3;
   localparam int PW  = RSZ + 16;

   logic            dac_clk_i = 1'b0;
   logic            dac_rst_i = 1'b0;
   logic            cfg_we_i = 1'b0;
   logic [SAW-1:0]  cfg_idx_i = '0;
   logic [PW-1:0]   cfg_ofs_i = '0;
   logic [PW-1:0]   cfg_size_i = '0;
   logic [15:0]     cfg_nrep_i = '0;
   logic [SAW-1:0]  cfg_last_i = '0;
   logic            cfg_loop_i = 1'b0;
   logic            start_i = 1'b0;
   logic            stop_i = 1'b0;
   logic            wrap_evt_i = 1'b0;
   logic [PW-1:0]   set_ofs_o;
   logic [PW-1:0]   set_size_o;
   logic            set_rst_o;
   logic            trig_sw_o;
   logic [2:0]      trig_src_o;
   logic [SAW-1:0]  seg_o;
   logic            busy_o;
   logic            done_o;
   logic            cfg_err_o;

   int n_checks = 0;
   int n_fail   = 0;

   asg_seq_ctrl #(.RSZ(RSZ), .SAW(SAW)) dut (
      .dac_clk_i  (dac_clk_i),
      .dac_rst_i  (dac_rst_i),
      .cfg_we_i   (cfg_we_i),
      .cfg_idx_i  (cfg_idx_i),
      .cfg_ofs_i  (cfg_ofs_i),
      .cfg_size_i (cfg_size_i),
      .cfg_nrep_i (cfg_nrep_i),
      .cfg_last_i (cfg_last_i),
      .cfg_loop_i (cfg_loop_i),
      .start_i    (start_i),
      .stop_i     (stop_i),
      .wrap_evt_i (wrap_evt_i),
      .set_ofs_o  (set_ofs_o),
      .set_size_o (set_size_o),
      .set_rst_o  (set_rst_o),
      .trig_sw_o  (trig_sw_o),
      .trig_src_o (trig_src_o),
      .seg_o      (seg_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .cfg_err_o  (cfg_err_o)
   );

   always #5 dac_clk_i = ~dac_clk_i;

   task automatic step();
      @(posedge dac_clk_i);
      #1;
   endtask

   task automatic write_entry(input logic [SAW-1:0] idx, input logic [PW-1:0] ofs,
                              input logic [PW-1:0] size, input logic [15:0] nrep);
      cfg_we_i = 1'b1; cfg_idx_i = idx; cfg_ofs_i = ofs; cfg_size_i = size; cfg_nrep_i = nrep;
      step();
      cfg_we_i = 1'b0;
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
   endtask

   task automatic pulse_stop();
      stop_i = 1'b1;
      step();
      stop_i = 1'b0;
   endtask

   task automatic pulse_wrap();
      wrap_evt_i = 1'b1;
      step();
      wrap_evt_i = 1'b0;
   endtask

   task automatic test_reset();
      dac_rst_i = 1'b1;
      step();
      step();
      dac_rst_i = 1'b0;
      #1;
      n_checks++;
      if ({set_ofs_o, set_size_o, set_rst_o, trig_sw_o, trig_src_o, seg_o, busy_o, done_o, cfg_err_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: ofs=%0h size=%0h rst=%0b sw=%0b src=%0d seg=%0d busy=%0b done=%0b err=%0b, required all 0",
                  set_ofs_o, set_size_o, set_rst_o, trig_sw_o, trig_src_o, seg_o, busy_o, done_o, cfg_err_o);
      end
   endtask

   task automatic test_single_segment();
      write_entry(3'd0, 30'h0, 30'h3FFF_FFFF, 16'd2);
      cfg_last_i = 3'd0; cfg_loop_i = 1'b0;
      pulse_start();
      n_checks++;
      if (set_rst_o !== 1'b1 || trig_sw_o !== 1'b0 || busy_o !== 1'b1 || trig_src_o !== 3'd1) begin
         n_fail++;
         $display("FAIL load_cycle: rst=%0b sw=%0b busy=%0b src=%0d, required 1 0 1 1", set_rst_o, trig_sw_o, busy_o, trig_src_o);
      end
      step();
      n_checks++;
      if (trig_sw_o !== 1'b1 || set_rst_o !== 1'b0 || set_size_o !== 30'h3FFF_FFFF || set_ofs_o !== 30'h0) begin
         n_fail++;
         $display("FAIL arm_cycle: sw=%0b rst=%0b size=%0h ofs=%0h, required 1 0 3fffffff 0", trig_sw_o, set_rst_o, set_size_o, set_ofs_o);
      end
      step();
      pulse_wrap();
      pulse_wrap();
      n_checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL early_done: done=%0b busy=%0b, required 0 1", done_o, busy_o);
      end
      pulse_wrap();
      n_checks++;
      if (done_o !== 1'b1) begin
         n_fail++;
         $display("FAIL done_pulse: done=%0b, required 1", done_o);
      end
      step();
      n_checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || trig_src_o !== 3'd0) begin
         n_fail++;
         $display("FAIL after_done: busy=%0b done=%0b src=%0d, required 0 0 0", busy_o, done_o, trig_src_o);
      end
   endtask

   task automatic test_sequence_stop();
      logic [PW-1:0]  exp_ofs [3];
      logic [SAW-1:0] exp_seq [4];
      exp_ofs[0] = 30'h0001_0000; exp_ofs[1] = 30'h0002_0000; exp_ofs[2] = 30'h0003_0000;
      exp_seq[0] = 3'd0; exp_seq[1] = 3'd1; exp_seq[2] = 3'd2; exp_seq[3] = 3'd0;
      for (int i = 0; i < 3; i++)
         write_entry(3'(i), exp_ofs[i], 30'h0010_0000, 16'd1);
      cfg_last_i = 3'd2; cfg_loop_i = 1'b1;
      pulse_start();
      for (int k = 0; k < 4; k++) begin
         step();
         n_checks++;
         if (seg_o !== exp_seq[k] || set_ofs_o !== exp_ofs[exp_seq[k]] || trig_sw_o !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_step%0d: seg=%0d ofs=%0h sw=%0b, required %0d %0h 1", k, seg_o, set_ofs_o, trig_sw_o, exp_seq[k], exp_ofs[exp_seq[k]]);
         end
         step();
         pulse_wrap();
         pulse_wrap();
         n_checks++;
         if (done_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_next%0d: done=%0b busy=%0b, required 0 1", k, done_o, busy_o);
         end
         step();
      end
      step();
      step();
      n_checks++;
      if (seg_o !== 3'd1 || busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL seq_before_stop: seg=%0d busy=%0b, required 1 1", seg_o, busy_o);
      end
      pulse_stop();
      n_checks++;
      if (busy_o !== 1'b0 || set_rst_o !== 1'b1 || done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_cycle: busy=%0b rst=%0b done=%0b, required 0 1 0", busy_o, set_rst_o, done_o);
      end
      for (int j = 0; j < 3; j++) begin
         step();
         n_checks++;
         if (set_rst_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_after%0d: rst=%0b done=%0b busy=%0b, required 0 0 0", j, set_rst_o, done_o, busy_o);
         end
      end
   endtask

   task automatic test_nrep_zero();
      write_entry(3'd0, 30'h0000_4000, 30'h0000_8000, 16'd0);
      cfg_last_i = 3'd0; cfg_loop_i = 1'b0;
      pulse_start();
      step();
      step();
      pulse_wrap();
      n_checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL nrep0_start_evt: done=%0b busy=%0b, required 0 1", done_o, busy_o);
      end
      pulse_wrap();
      n_checks++;
      if (done_o !== 1'b1) begin
         n_fail++;
         $display("FAIL nrep0_done: done=%0b, required 1", done_o);
      end
      step();
   endtask

   task automatic test_cfg_err();
      write_entry(3'd0, 30'h0000_0AAA, 30'h0000_0BBB, 16'd1);
      cfg_last_i = 3'd0; cfg_loop_i = 1'b0;
      pulse_start();
      step();
      step();
      write_entry(3'd0, 30'h0000_0555, 30'h0000_0666, 16'd7);
      n_checks++;
      if (cfg_err_o !== 1'b1) begin
         n_fail++;
         $display("FAIL cfg_err_set: err=%0b, required 1", cfg_err_o);
      end
      pulse_stop();
      n_checks++;
      if (cfg_err_o !== 1'b1 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg_err_sticky: err=%0b busy=%0b, required 1 0", cfg_err_o, busy_o);
      end
      pulse_start();
      n_checks++;
      if (cfg_err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg_err_clear: err=%0b, required 0", cfg_err_o);
      end
      step();
      n_checks++;
      if (set_ofs_o !== 30'h0000_0AAA || set_size_o !== 30'h0000_0BBB) begin
         n_fail++;
         $display("FAIL table_protect: ofs=%0h size=%0h, required aaa bbb", set_ofs_o, set_size_o);
      end
      pulse_stop();
   endtask

   task automatic test_start_stop_arm();
      start_i = 1'b1; stop_i = 1'b1;
      step();
      start_i = 1'b0; stop_i = 1'b0;
      n_checks++;
      if (busy_o !== 1'b0 || set_rst_o !== 1'b0) begin
         n_fail++;
         $display("FAIL start_and_stop: busy=%0b rst=%0b, required 0 0", busy_o, set_rst_o);
      end
      write_entry(3'd0, 30'h0000_1000, 30'h0000_2000, 16'd1);
      cfg_last_i = 3'd0; cfg_loop_i = 1'b0;
      pulse_start();
      wrap_evt_i = 1'b1;
      step();
      step();
      wrap_evt_i = 1'b0;
      pulse_wrap();
      n_checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL arm_wrap_ignored: done=%0b busy=%0b, required 0 1", done_o, busy_o);
      end
      pulse_wrap();
      n_checks++;
      if (done_o !== 1'b1) begin
         n_fail++;
         $display("FAIL arm_wrap_done: done=%0b, required 1", done_o);
      end
      step();
   endtask

   task automatic test_reset_mid_run();
      write_entry(3'd0, 30'h1234_5678, 30'h0100_0000, 16'd5);
      cfg_last_i = 3'd0; cfg_loop_i = 1'b0;
      pulse_start();
      step();
      step();
      pulse_wrap();
      n_checks++;
      if (set_ofs_o !== 30'h1234_5678 || busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset: ofs=%0h busy=%0b, required 12345678 1", set_ofs_o, busy_o);
      end
      dac_rst_i = 1'b1;
      step();
      dac_rst_i = 1'b0;
      n_checks++;
      if ({set_ofs_o, set_size_o, set_rst_o, trig_sw_o, trig_src_o, seg_o, busy_o, done_o, cfg_err_o} !== '0) begin
         n_fail++;
         $display("FAIL mid_run_reset: ofs=%0h size=%0h busy=%0b src=%0d, required all 0", set_ofs_o, set_size_o, busy_o, trig_src_o);
      end
      pulse_start();
      step();
      n_checks++;
      if (set_ofs_o !== 30'h0 || set_size_o !== 30'h0 || trig_sw_o !== 1'b1) begin
         n_fail++;
         $display("FAIL table_cleared: ofs=%0h size=%0h sw=%0b, required 0 0 1", set_ofs_o, set_size_o, trig_sw_o);
      end
      pulse_stop();
   endtask

   initial begin
      test_reset();
      test_single_segment();
      test_sequence_stop();
      test_nrep_zero();
      test_cfg_err();
      test_start_stop_arm();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
